// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default RAM address / data widths
//   requester_e             : who owns, who was last granted, who has a read in flight
//   cmd_t                   : one requester's command (we, lock, addr, wdata)
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 24;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_CORE = 2'd1,
    REQ_HOST = 2'd2
  } requester_e;

  typedef struct packed {
    logic                  we;
    logic                  lock;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester's access port into the data-memory arbiter.
//   req/we/lock/addr/wdata : command, held by the requester until gnt
//   gnt                    : command accepted this cycle
//   rvalid/rdata           : read response, one cycle after the read grant
// master = requester side (core or host), slave = arbiter side.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/dmem_rr_pick.sv
// Two-way grant decision for the data-memory arbiter (purely combinational).
//   core_req/host_req : live requests
//   last              : requester granted most recently (tie-break loser)
//   owner             : requester holding a lock, or REQ_NONE
//   at_max            : owner has used up its consecutive locked grants
//   pick              : requester to grant this cycle, REQ_NONE if idle
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic       core_req,
  input  logic       host_req,
  input  requester_e last,
  input  requester_e owner,
  input  logic       at_max,
  output requester_e pick
);

  logic       own_req;
  logic       peer_req;
  requester_e peer;

  always_comb begin
    own_req  = 1'b0;
    peer_req = 1'b0;
    peer     = REQ_NONE;
    if (owner == REQ_CORE) begin
      own_req  = core_req;
      peer_req = host_req;
      peer     = REQ_HOST;
    end else if (owner == REQ_HOST) begin
      own_req  = host_req;
      peer_req = core_req;
      peer     = REQ_CORE;
    end
  end

  always_comb begin
    pick = REQ_NONE;
    if (owner != REQ_NONE && own_req && !at_max) begin
      pick = owner;
    end else if (owner != REQ_NONE && own_req && at_max) begin
      // Burst exhausted: yield only if the peer is actually waiting.
      pick = peer_req ? peer : owner;
    end else if (core_req && host_req) begin
      pick = (last == REQ_CORE) ? REQ_HOST : REQ_CORE;
    end else if (core_req) begin
      pick = REQ_CORE;
    end else if (host_req) begin
      pick = REQ_HOST;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data RAM between the core load/store port
// and the host/debug port.
//   clk, reset      : clock, synchronous active-high reset
//   core, host      : requester ports (dmem_arbiter_if.slave)
//   ram_addr/wdata/we : RAM command of the granted requester
//   ram_rdata       : RAM read data, one cycle after the address
//   conflict_cnt    : saturating count of cycles with both requests high
// Grants are combinational; read responses come one cycle after the grant
// and are routed to the requester that issued the read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
)(
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     core,
  dmem_arbiter_if.slave     host,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  requester_e         owner;
  requester_e         last;
  logic [BURST_W-1:0] burst_cnt;
  requester_e         rd_pend_p1;

  logic       at_max;
  requester_e pick;
  requester_e grant;
  cmd_t       core_cmd;
  cmd_t       host_cmd;
  cmd_t       sel_cmd;

  assign at_max = (burst_cnt == BURST_MAX);

  dmem_rr_pick u_pick (
    .core_req (core.req),
    .host_req (host.req),
    .last     (last),
    .owner    (owner),
    .at_max   (at_max),
    .pick     (pick)
  );

  // Stage p0: grant and RAM command mux (combinational)
  always_comb begin
    grant = reset ? REQ_NONE : pick;
  end

  always_comb begin
    core_cmd = '{we: core.we, lock: core.lock, addr: core.addr, wdata: core.wdata};
    host_cmd = '{we: host.we, lock: host.lock, addr: host.addr, wdata: host.wdata};
    sel_cmd  = core_cmd;
    if (grant == REQ_HOST) sel_cmd = host_cmd;
  end

  assign core.gnt  = (grant == REQ_CORE);
  assign host.gnt  = (grant == REQ_HOST);
  assign ram_addr  = sel_cmd.addr;
  assign ram_wdata = sel_cmd.wdata;
  assign ram_we    = (grant != REQ_NONE) && sel_cmd.we;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner        <= REQ_NONE;
      last         <= REQ_HOST;
      burst_cnt    <= '0;
      rd_pend_p1   <= REQ_NONE;
      conflict_cnt <= '0;
    end else begin
      if (grant != REQ_NONE) begin
        last <= grant;
        if (sel_cmd.lock) begin
          owner <= grant;
          // A fresh owner starts its burst at 1; a continuing owner counts up
          // and parks at the limit while nobody else is waiting.
          if (grant != owner) burst_cnt <= BURST_W'(1);
          else if (!at_max)   burst_cnt <= burst_cnt + 1'b1;
        end else begin
          owner     <= REQ_NONE;
          burst_cnt <= '0;
        end
      end else begin
        owner     <= REQ_NONE;
        burst_cnt <= '0;
      end
      rd_pend_p1 <= (grant != REQ_NONE && !sel_cmd.we) ? grant : REQ_NONE;
      if (core.req && host.req && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  // Stage p1: read response routing
  // Gated by reset so a read granted just before reset never completes.
  assign core.rvalid = (rd_pend_p1 == REQ_CORE) && !reset;
  assign host.rvalid = (rd_pend_p1 == REQ_HOST) && !reset;
  assign core.rdata  = ram_rdata;
  assign host.rdata  = ram_rdata;

endmodule
